operand_feeder: RTL
===================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter ADDR_W, default 7, memory read-address width.
REQ-002 Parameter DATA_W, default 16, element width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to load and stream one 4x4 A/B operand pair.
REQ-006 base_A  input  ADDR_W  address of A[0][0], sampled with start.
REQ-007 base_B  input  ADDR_W  address of B[0][0], sampled with start.
REQ-008 en_A  output  1  read enable to operand memory port A.
REQ-009 en_B  output  1  read enable to operand memory port B.
REQ-010 read_addr_A  output  ADDR_W  memory port A address.
REQ-011 read_addr_B  output  ADDR_W  memory port B address.
REQ-012 read_data_A  input  DATA_W  port A data, valid one cycle after en_A.
REQ-013 read_data_B  input  DATA_W  port B data, valid one cycle after en_B.
REQ-014 a_out  output  4*DATA_W  row lanes to the array's left edge; lane i in bits [DATA_W*i +: DATA_W].
REQ-015 b_out  output  4*DATA_W  column lanes to the array's top edge; same packing.
REQ-016 valid  output  1  a_out/b_out carry a stream beat.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse at end of stream.
REQ-019 err  output  1  sticky start-while-busy flag (see Configuration).

Function
REQ-020 FSM states IDLE, LOAD, STREAM, DONE; IDLE->LOAD on start; LOAD->STREAM after 16th capture; STREAM->DONE after beat 6; DONE->IDLE unconditionally.
REQ-021 start outside IDLE is ignored; base addresses are not resampled.
REQ-022 LOAD issues reads n=0..15 on 16 consecutive cycles starting the cycle after start; en_A=en_B=1 only on issue cycles.
REQ-023 Issue n: read_addr_A = base_A + n, read_addr_B = base_B + n, modulo 2^ADDR_W (wrap, no error).
REQ-024 Data captured one cycle after issue; read_data_A at issue n stored as A[n/4][n%4], read_data_B as B[n/4][n%4] (row-major).
REQ-025 Addresses hold last issued value while en is low; outputs are don't-care to memory then.
REQ-026 STREAM lasts exactly 7 cycles, beat t=0..6, valid=1 every beat.
REQ-027 Beat t: a_out lane i = A[i][t-i] if 0<=t-i<=3, else 0; b_out lane j = B[t-j][j] if 0<=t-j<=3, else 0.
REQ-028 Outside STREAM a_out=b_out=0, valid=0.
REQ-029 Timing: start sampled at cycle c -> issues c+1..c+16, captures c+2..c+17, beats c+18..c+24, done=1 at c+25, busy low at c+26, new start accepted at c+26.
REQ-030 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-031 rst_n low forces IDLE immediately, regardless of state; in-flight load/stream is discarded.
REQ-032 Reset values: en_A=en_B=0, read_addr_A=read_addr_B=0, a_out=b_out=0, valid=busy=done=err=0.
REQ-033 Operand buffers need not be cleared by reset; they are fully overwritten before any beat.

Configuration
REQ-034 Macro FEEDER_BUSY_ERR_EN defined: err sets on any cycle start=1 while busy=1, holds until rst_n low.
REQ-035 Macro undefined: err tied to 0; start-while-busy still ignored per REQ-021.

Verification
REQ-036 Memory model mem[n]=n, base_A=0, base_B=16, start -> beat 0: a_out lane0=0, b_out lane0=16, other lanes 0; beat 3: a_out lanes {0..3}={3,6,9,12}, b_out lanes {0..3}={28,25,22,19}; beat 6: a_out lane3=15, b_out lane3=31, others 0.
REQ-037 Same run -> en_A high exactly 16 cycles (c+1..c+16), valid high exactly 7 cycles, done single pulse at c+25.
REQ-038 base_A=120 -> read_addr_A sequence 120..127,0..7; A[2][0] captured from address 0.
REQ-039 start pulsed again at c+5 -> ignored, timing unchanged; err=1 with FEEDER_BUSY_ERR_EN, err=0 without.
REQ-040 rst_n low at c+20 (mid-STREAM) -> next edge outputs all 0, busy=0; fresh start after release yields correct REQ-036 beats.
REQ-041 Back-to-back: second start at c+26 -> second done at c+51, no gap errors.

Source files
------------

// File: rtl/operand_feeder.sv
// Loads a 4x4 A/B operand pair from two registered-read memory ports and streams it skewed
// onto the systolic array edges. Define FEEDER_BUSY_ERR_EN to enable the sticky start-while-busy flag.
module operand_feeder #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_A,
   input  logic [ADDR_W-1:0]     base_B,
   output logic                  en_A,
   output logic                  en_B,
   output logic [ADDR_W-1:0]     read_addr_A,
   output logic [ADDR_W-1:0]     read_addr_B,
   input  logic [DATA_W-1:0]     read_data_A,
   input  logic [DATA_W-1:0]     read_data_B,
   output logic [4*DATA_W-1:0]   a_out,
   output logic [4*DATA_W-1:0]   b_out,
   output logic                  valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

   state_t              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [2:0]          beat_q, beat_d;
   logic                en_q, en_d;
   logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
   logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
   logic [4*DATA_W-1:0] a_out_q, a_out_d;
   logic [4*DATA_W-1:0] b_out_q, b_out_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                cap;
   logic [3:0]          cap_idx;
   logic                emit;
   logic [2:0]          emit_beat;
   logic [3:0]          off;

   logic [DATA_W-1:0]   a_buf_q [16];
   logic [DATA_W-1:0]   b_buf_q [16];

   // cnt_q counts LOAD cycles 0..16: cycle k issues read k (k<=15) and captures read k-1 (k>=1)
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      beat_d    = beat_q;
      en_d      = 1'b0;
      addr_a_d  = addr_a_q;
      addr_b_d  = addr_b_q;
      done_d    = 1'b0;
      cap       = 1'b0;
      cap_idx   = 4'(cnt_q - 5'd1);
      emit      = 1'b0;
      emit_beat = 3'd0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD;
               cnt_d    = 5'd0;
               en_d     = 1'b1;
               addr_a_d = base_A;
               addr_b_d = base_B;
            end
         end
         LOAD: begin
            cnt_d = cnt_q + 5'd1;
            cap   = (cnt_q != 5'd0);
            if (cnt_q < 5'd15) begin
               en_d     = 1'b1;
               addr_a_d = addr_a_q + ADDR_W'(1);
               addr_b_d = addr_b_q + ADDR_W'(1);
            end
            if (cnt_q == 5'd16) begin
               state_d   = STREAM;
               cnt_d     = 5'd0;
               beat_d    = 3'd0;
               emit      = 1'b1;
               emit_beat = 3'd0;
            end
         end
         STREAM: begin
            if (beat_q == 3'd6) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               beat_d    = beat_q + 3'd1;
               emit      = 1'b1;
               emit_beat = beat_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      valid_d = emit;
      busy_d  = (state_d != IDLE);
`ifdef FEEDER_BUSY_ERR_EN
      err_d   = err_q | (start & busy_q);
`else
      err_d   = 1'b0;
`endif
   end

   // Diagonal skew: row lane i carries A[i][t-i], column lane j carries B[t-j][j]
   always_comb begin
      a_out_d = '0;
      b_out_d = '0;
      off     = '0;
      for (int i = 0; i < 4; i++) begin
         off = {1'b0, emit_beat} - 4'(i);
         if (emit && ({1'b0, emit_beat} >= 4'(i)) && (off <= 4'd3)) begin
            a_out_d[i*DATA_W +: DATA_W] = a_buf_q[{2'(i), off[1:0]}];
            b_out_d[i*DATA_W +: DATA_W] = b_buf_q[{off[1:0], 2'(i)}];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         beat_q   <= 3'd0;
         en_q     <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         a_out_q  <= '0;
         b_out_q  <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         beat_q   <= beat_d;
         en_q     <= en_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         a_out_q  <= a_out_d;
         b_out_q  <= b_out_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Operand buffers are fully rewritten before any beat reads them, so they carry no reset
   always_ff @(posedge clk) begin
      if (cap) begin
         a_buf_q[cap_idx] <= read_data_A;
         b_buf_q[cap_idx] <= read_data_B;
      end
   end

   assign en_A        = en_q;
   assign en_B        = en_q;
   assign read_addr_A = addr_a_q;
   assign read_addr_B = addr_b_q;
   assign a_out       = a_out_q;
   assign b_out       = b_out_q;
   assign valid       = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule
